seq_product_divider: RTL and testbench

Sequential radix-2 restoring divider that inverts the datapath's (2n+1)-bit product format: divides a (2n+1)-bit dividend by an (n+1)-bit divisor to recover the (n+1)-bit quotient and remainder. It sits downstream of the combinational multiplier and recovers one operand from a product and the other operand. It also serves as a general fixed-latency divide unit. It uses a valid/ready handshake on both sides and processes one operation at a time.

---
 rtl/seq_product_divider.sv | 185 ++++++++++++++++++
 tb/tb_seq_product_divider.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_product_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_product_divider
// Description : Radix-2 restoring divider, (2N+1)-bit dividend by (N+1)-bit
//               divisor, valid/ready on both sides, one operation in flight.
//               Define SEQ_DIV_SIGNED_EN for two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_product_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2*N:0] dividend,
    input  logic [N:0]   divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   quotient,
    output logic [N:0]   remainder,
    output logic         ovf,
    output logic         dz
);

    localparam int c_cnt_w = $clog2(2*N+1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(2*N);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [2*N:0] c_q_pos_max = {{N{1'b0}}, 1'b0, {N{1'b1}}};
    localparam logic [2*N:0] c_q_neg_max = {{N{1'b0}}, 1'b1, {N{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2*N:0]         r_dvd;
    logic [N:0]           r_dvs;
    logic [N+1:0]         r_rem;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_zero;
    logic [N:0]           r_quotient;
    logic [N:0]           r_remainder;
    logic                 r_ovf;
    logic                 r_dz;
`ifdef SEQ_DIV_SIGNED_EN
    logic                 r_sa;
    logic                 r_sb;
`endif

    logic                 w_accept;
    logic                 w_dvs_zero;
    logic [2*N:0]         w_dvd_mag;
    logic [N:0]           w_dvs_mag;
    logic [N+2:0]         w_shift;
    logic [N+2:0]         w_diff;
    logic                 w_qbit;
    logic                 w_q_neg;
    logic                 w_r_neg;
    logic [N:0]           w_quot_fix;
    logic [N:0]           w_rem_src;
    logic [N:0]           w_rem_fix;
    logic                 w_ovf_fix;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign quotient   = r_quotient;
    assign remainder  = r_remainder;
    assign ovf        = r_ovf;
    assign dz         = r_dz;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_dvs_zero = (divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
    assign w_dvd_mag  = dividend[2*N] ? -dividend : dividend;
    assign w_dvs_mag  = divisor[N]    ? -divisor  : divisor;
    assign w_q_neg    = r_sa ^ r_sb;
    assign w_r_neg    = r_sa;
    assign w_ovf_fix  = w_q_neg ? (r_dvd > c_q_neg_max) : (r_dvd > c_q_pos_max);
`else
    assign w_dvd_mag  = dividend;
    assign w_dvs_mag  = divisor;
    assign w_q_neg    = 1'b0;
    assign w_r_neg    = 1'b0;
    assign w_ovf_fix  = |r_dvd[2*N:N+1];
`endif

    // Restoring step: shift the next dividend bit into the partial remainder
    assign w_shift    = {r_rem, r_dvd[2*N]};
    assign w_diff     = w_shift - {2'b00, r_dvs};
    assign w_qbit     = ~w_diff[N+2];

    // Zero divisor leaves the dividend magnitude untouched, so re-applying
    // its sign recovers the raw low dividend bits for the remainder.
    assign w_quot_fix = w_q_neg ? -r_dvd[N:0] : r_dvd[N:0];
    assign w_rem_src  = r_zero ? r_dvd[N:0] : r_rem[N:0];
    assign w_rem_fix  = w_r_neg ? -w_rem_src : w_rem_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = w_dvs_zero ? S_FIX : S_DIV;
            S_DIV:   if (r_cnt == '0) w_state_next = S_FIX;
            S_FIX:   if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_zero      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
`endif
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvd  <= w_dvd_mag;
                        r_dvs  <= w_dvs_mag;
                        r_rem  <= '0;
                        r_zero <= w_dvs_zero;
                        // Zero divisor: FIX is held one extra cycle so the
                        // flagged result appears two edges after accept.
                        r_cnt  <= w_dvs_zero ? c_cnt_one : c_cnt_full;
`ifdef SEQ_DIV_SIGNED_EN
                        r_sa   <= dividend[2*N];
                        r_sb   <= divisor[N];
`endif
                    end
                end
                S_DIV: begin
                    r_dvd <= {r_dvd[2*N-1:0], w_qbit};
                    r_rem <= w_qbit ? w_diff[N+1:0] : w_shift[N+1:0];
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_FIX: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= w_rem_fix;
                        r_ovf       <= 1'b0;
                        r_dz        <= 1'b1;
                    end else begin
                        r_quotient  <= w_quot_fix;
                        r_remainder <= w_rem_fix;
                        r_ovf       <= w_ovf_fix;
                        r_dz        <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_product_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_product_divider
// Description : Self-checking bench for seq_product_divider against an
//               integer-arithmetic reference model (signed or unsigned build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_product_divider;

    localparam int N   = 8;
    localparam int LAT = 2*N+2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2*N:0] dividend;
    logic [N:0]   divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   quotient;
    logic [N:0]   remainder;
    logic         ovf;
    logic         dz;

    int n_vec    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = -1;
    int prev_acc = -1;

    logic [2*N:0] a, a2;
    logic [N:0]   b, b2;
    logic [N:0]   eq;
    logic [N:0]   er;
    logic         eo, ez;
    int           seen;

    seq_product_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            prev_acc <= last_acc;
            last_acc <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division, truncating toward zero.
    function automatic void model(input logic [2*N:0] x, input logic [N:0] y,
                                  output logic [N:0] q, output logic [N:0] r,
                                  output logic o, output logic z);
        longint sx, sy, qq, rr;
        if (y == '0) begin
            q = '1;
            r = x[N:0];
            o = 1'b0;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            qq = sx / sy;
            rr = sx % sy;
            o  = (qq > longint'(2**N - 1)) || (qq < -longint'(2**N));
`else
            sx = longint'(x);
            sy = longint'(y);
            qq = sx / sy;
            rr = sx % sy;
            o  = (qq > longint'(2**(N+1) - 1));
`endif
            q = qq[N:0];
            r = rr[N:0];
            z = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 4*LAT; i++) begin
            if (in_ready) break;
            @(posedge clk);
            #1;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Presents one operation, returns 1 time unit after the accept edge
    // with the inputs scrambled to prove they are sampled only at accept.
    task automatic start(input logic [2*N:0] x, input logic [N:0] y);
        wait_ready();
        dividend = x;
        divisor  = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = (2*N+1)'($urandom);
        divisor  = (N+1)'($urandom);
    endtask

    task automatic finish_op(input logic [2*N:0] x, input logic [N:0] y);
        logic [N:0] q, r;
        logic o, z;
        int lat;
        model(x, y, q, r, o, z);
        lat = 0;
        for (int i = 1; i <= 4*LAT; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency",   lat, (y == '0) ? 2 : LAT);
        chk("quotient",  {23'd0, quotient},  {23'd0, q});
        chk("remainder", {23'd0, remainder}, {23'd0, r});
        chk("ovf",       {31'd0, ovf},       {31'd0, o});
        chk("dz",        {31'd0, dz},        {31'd0, z});
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("in_ready_back",  {31'd0, in_ready},  32'd1);
    endtask

    task automatic op(input logic [2*N:0] x, input logic [N:0] y);
        start(x, y);
        finish_op(x, y);
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient",  {23'd0, quotient},  32'd0);
        chk("rst_remainder", {23'd0, remainder}, 32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        chk("rst_dz",        {31'd0, dz},        32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        op(17'd1000,   9'd7);
        op(17'h1FC18,  9'd7);
        op(17'h1FF00,  9'd1);
        op(17'd256,    9'd1);
        op(17'd65535,  9'd1);
        op(17'd123,    9'd0);
        op(17'd65535,  9'd255);
        op(17'h10000,  9'h1FF);
        op(17'h1FFFB,  9'd0);

        // Backpressure: result held, in_valid ignored while busy
        out_ready = 1'b0;
        a = 17'd40000;
        b = 9'h1F3;
        start(a, b);
        finish_op(a, b);
        model(a, b, eq, er, eo, ez);
        in_valid = 1'b1;
        dividend = 17'd5;
        divisor  = 9'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_quotient",  {23'd0, quotient},  {23'd0, eq});
            chk("bp_remainder", {23'd0, remainder}, {23'd0, er});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Back-to-back with in_valid held high
        a  = 17'd30000; b  = 9'd13;
        a2 = 17'h1E000; b2 = 9'h1F0;
        wait_ready();
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        dividend = a2;
        divisor  = b2;
        finish_op(a, b);
        @(posedge clk);
        #1;
        chk("b2b_out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("b2b_in_ready",       {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_spacing", last_acc - prev_acc, 2*N+4);
        finish_op(a2, b2);
        drain();

        // Reset in the middle of DIV
        start(17'd50000, 9'd3);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_quotient",  {23'd0, quotient},  32'd0);
        chk("mid_rst_remainder", {23'd0, remainder}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2*LAT; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 0);
        chk("mid_rst_idle",      {31'd0, in_ready}, 32'd1);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            a = (2*N+1)'($urandom);
            if (k % 3 == 0) a = {{8{a[2*N]}}, a[2*N:8]};
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = (N+1)'($urandom_range(1, 3));
                2:       b = '1;
                default: b = (N+1)'($urandom);
            endcase
            op(a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
